// File: rtl/me_pkg.sv
// Shared definitions for the motion-estimation search engine.
//   clog2       : ceiling log2 that can be evaluated at elaboration time
//   sad_w       : width that holds the worst-case block SAD exactly
//   row_sad_w   : width that holds the worst-case single-row SAD exactly
//   mv_w        : motion-vector component width for a search range
//   me_state_e  : controller states (ACC, FLUSH, OUT)
//   FLUSH_CYC   : cycles spent draining the accumulate/compare stages
package me_pkg;

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    FLUSH = 2'd1,
    OUT   = 2'd2
  } me_state_e;

  localparam int FLUSH_CYC = 2;

  function automatic int clog2(input longint unsigned v);
    int r;
    r = 0;
    while ((64'd1 << r) < v) r++;
    return r;
  endfunction

  function automatic int sad_w(input int pix_w, input int blk_w, input int blk_h);
    return clog2(longint'(blk_w) * longint'(blk_h) * ((longint'(1) << pix_w) - 1) + 1);
  endfunction

  function automatic int row_sad_w(input int pix_w, input int blk_w);
    return clog2(longint'(blk_w) * ((longint'(1) << pix_w) - 1) + 1);
  endfunction

  function automatic int mv_w(input int sr);
    return clog2(longint'(sr));
  endfunction

endpackage

// File: rtl/me_row_sad.sv
// Row SAD: sum over BLK_W pixels of |cur - ref|, registered.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   cur_row_i      current-block row, pixel 0 in the LSBs
//   ref_row_i      reference row, same packing
//   row_sad_o      registered row SAD (one cycle after the inputs)
module me_row_sad
  import me_pkg::*;
#(
  parameter  int PIX_W = 8,
  parameter  int BLK_W = 8,
  localparam int RS_W  = row_sad_w(PIX_W, BLK_W)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [BLK_W*PIX_W-1:0] cur_row_i,
  input  logic [BLK_W*PIX_W-1:0] ref_row_i,
  output logic [RS_W-1:0]        row_sad_o
);

  logic [RS_W-1:0] row_sad_d;
  logic [RS_W-1:0] row_sad_q;

  function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // Written as a chain; synthesis rebalances it into a tree.
  always_comb begin
    row_sad_d = '0;
    for (int p = 0; p < BLK_W; p++) begin
      row_sad_d = row_sad_d + RS_W'(abs_diff(cur_row_i[p*PIX_W +: PIX_W],
                                             ref_row_i[p*PIX_W +: PIX_W]));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) row_sad_q <= '0;
    else       row_sad_q <= row_sad_d;
  end

  assign row_sad_o = row_sad_q;

endmodule

// File: rtl/me_search_engine.sv
// Full-search motion-estimation engine. Takes (current row, reference row)
// beats for every candidate displacement of one block in raster order
// (row fastest, then vx, then vy), accumulates SAD per candidate, keeps the
// earliest minimum and presents best SAD plus signed motion vector.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     beat handshake; in_sob marks candidate 0 row 0
//   cur_row, ref_row      pixel rows, pixel 0 in the LSBs
//   res_valid/res_ready   result handshake
//   res_sad               minimum SAD
//   res_mv_x, res_mv_y    signed vector: vx - SR_X/2, vy - SR_Y/2
// Optional build macro ME_SERIAL_OUT_EN adds ser_en, ser_sad, ser_x, ser_y:
// the captured result is shifted out MSB-first over SAD_W cycles, and OUT
// is left only after both the handshake and the shift have finished.
//
// state | meaning
// ACC   | accepting beats, accumulating candidate SADs
// FLUSH | no new beats; draining the accumulate and compare stages
// OUT   | result held on res_*, waiting for the downstream handshake
module me_search_engine
  import me_pkg::*;
#(
  parameter  int PIX_W = 8,
  parameter  int BLK_W = 8,
  parameter  int BLK_H = 16,
  parameter  int SR_X  = 16,
  parameter  int SR_Y  = 16,
  localparam int SAD_W = sad_w(PIX_W, BLK_W, BLK_H),
  localparam int MV_XW = mv_w(SR_X),
  localparam int MV_YW = mv_w(SR_Y)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sob,
  input  logic [BLK_W*PIX_W-1:0]  cur_row,
  input  logic [BLK_W*PIX_W-1:0]  ref_row,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [SAD_W-1:0]        res_sad,
  output logic signed [MV_XW-1:0] res_mv_x,
  output logic signed [MV_YW-1:0] res_mv_y
`ifdef ME_SERIAL_OUT_EN
  ,
  output logic                    ser_en,
  output logic                    ser_sad,
  output logic                    ser_x,
  output logic                    ser_y
`endif
);

  localparam int ROW_W = (BLK_H > 1) ? clog2(BLK_H) : 1;
  localparam int RS_W  = row_sad_w(PIX_W, BLK_W);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(BLK_H - 1);
  localparam logic [MV_XW-1:0] VX_LAST  = MV_XW'(SR_X - 1);
  localparam logic [MV_YW-1:0] VY_LAST  = MV_YW'(SR_Y - 1);
  localparam logic [MV_XW-1:0] MV_X_OFS = MV_XW'(SR_X / 2);
  localparam logic [MV_YW-1:0] MV_Y_OFS = MV_YW'(SR_Y / 2);

  // controller
  me_state_e        state_q;
  logic             in_ready_q;
  logic             res_valid_q;
  logic [1:0]       flush_cnt_q;
  logic [ROW_W-1:0] row_q;
  logic [MV_XW-1:0] vx_q;
  logic [MV_YW-1:0] vy_q;

  // stage 1 tags (row SAD itself is registered in me_row_sad)
  logic [RS_W-1:0]  row_sad;
  logic             s1_vld_q, s1_row0_q, s1_lrow_q, s1_first_q, s1_last_q;
  logic [MV_XW-1:0] s1_vx_q;
  logic [MV_YW-1:0] s1_vy_q;

  // stage 2
  logic [SAD_W-1:0] cand_sad_q;
  logic             s2_done_q, s2_first_q, s2_last_q;
  logic [MV_XW-1:0] s2_vx_q;
  logic [MV_YW-1:0] s2_vy_q;

  // stage 3
  logic [SAD_W-1:0] min_sad_q;
  logic [MV_XW-1:0] min_vx_q;
  logic [MV_YW-1:0] min_vy_q;
  logic [SAD_W-1:0] res_sad_q;
  logic [MV_XW-1:0] res_mv_x_q;
  logic [MV_YW-1:0] res_mv_y_q;

  logic             beat_acc, sob_acc, last_beat;
  logic [ROW_W-1:0] pos_row;
  logic [MV_XW-1:0] pos_vx;
  logic [MV_YW-1:0] pos_vy;
  logic             at_last_row, at_last_vx, at_last_vy;
  logic             s3_take, res_load;
  logic [SAD_W-1:0] best_sad;
  logic [MV_XW-1:0] best_vx, best_mv_x;
  logic [MV_YW-1:0] best_vy, best_mv_y;
  logic             res_hs;

  me_row_sad #(
    .PIX_W (PIX_W),
    .BLK_W (BLK_W)
  ) u_row_sad (
    .clk_i     (clk),
    .rst_i     (rst),
    .cur_row_i (cur_row),
    .ref_row_i (ref_row),
    .row_sad_o (row_sad)
  );

  // An accepted in_sob beat is itself candidate 0 row 0, so its position
  // is forced to zero before tagging and advancing.
  assign beat_acc    = in_valid && in_ready_q;
  assign sob_acc     = beat_acc && in_sob;
  assign pos_row     = sob_acc ? '0 : row_q;
  assign pos_vx      = sob_acc ? '0 : vx_q;
  assign pos_vy      = sob_acc ? '0 : vy_q;
  assign at_last_row = (pos_row == ROW_LAST);
  assign at_last_vx  = (pos_vx == VX_LAST);
  assign at_last_vy  = (pos_vy == VY_LAST);
  assign last_beat   = beat_acc && at_last_row && at_last_vx && at_last_vy;

  // First candidate loads unconditionally; strict compare keeps the
  // earliest candidate on ties.
  assign s3_take   = s2_done_q && (s2_first_q || (cand_sad_q < min_sad_q));
  assign best_sad  = s3_take ? cand_sad_q : min_sad_q;
  assign best_vx   = s3_take ? s2_vx_q : min_vx_q;
  assign best_vy   = s3_take ? s2_vy_q : min_vy_q;
  assign best_mv_x = best_vx - MV_X_OFS;
  assign best_mv_y = best_vy - MV_Y_OFS;
  assign res_load  = s2_done_q && s2_last_q;
  assign res_hs    = res_valid_q && res_ready;

`ifdef ME_SERIAL_OUT_EN
  localparam int SC_W = clog2(SAD_W + 1);

  logic [SC_W-1:0]  ser_cnt_q;
  logic [SAD_W-1:0] ser_sad_q;
  logic [MV_XW-1:0] ser_x_q;
  logic [MV_YW-1:0] ser_y_q;
  logic             taken_q;
  logic             ser_idle;

  assign ser_idle = (ser_cnt_q == '0);

  // Zeros shift in behind the data, so each line reads 0 once its field
  // has been emitted.
  always_ff @(posedge clk) begin
    if (rst) begin
      ser_cnt_q <= '0;
      ser_sad_q <= '0;
      ser_x_q   <= '0;
      ser_y_q   <= '0;
    end else if (res_load) begin
      ser_cnt_q <= SC_W'(SAD_W);
      ser_sad_q <= best_sad;
      ser_x_q   <= best_mv_x;
      ser_y_q   <= best_mv_y;
    end else if (!ser_idle) begin
      ser_cnt_q <= ser_cnt_q - SC_W'(1);
      ser_sad_q <= ser_sad_q << 1;
      ser_x_q   <= ser_x_q << 1;
      ser_y_q   <= ser_y_q << 1;
    end
  end

  assign ser_en  = !ser_idle;
  assign ser_sad = ser_sad_q[SAD_W-1];
  assign ser_x   = ser_x_q[MV_XW-1];
  assign ser_y   = ser_y_q[MV_YW-1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACC;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      flush_cnt_q <= '0;
      row_q       <= '0;
      vx_q        <= '0;
      vy_q        <= '0;
`ifdef ME_SERIAL_OUT_EN
      taken_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        ACC: begin
          in_ready_q <= 1'b1;
          if (beat_acc) begin
            if (last_beat) begin
              state_q     <= FLUSH;
              in_ready_q  <= 1'b0;
              flush_cnt_q <= 2'(FLUSH_CYC - 1);
              row_q       <= '0;
              vx_q        <= '0;
              vy_q        <= '0;
            end else if (at_last_row) begin
              row_q <= '0;
              if (at_last_vx) begin
                vx_q <= '0;
                vy_q <= pos_vy + MV_YW'(1);
              end else begin
                vx_q <= pos_vx + MV_XW'(1);
                vy_q <= pos_vy;
              end
            end else begin
              row_q <= pos_row + ROW_W'(1);
              vx_q  <= pos_vx;
              vy_q  <= pos_vy;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt_q == '0) begin
            state_q     <= OUT;
            res_valid_q <= 1'b1;
          end else begin
            flush_cnt_q <= flush_cnt_q - 2'd1;
          end
        end
        OUT: begin
`ifdef ME_SERIAL_OUT_EN
          if (res_hs) begin
            res_valid_q <= 1'b0;
            taken_q     <= 1'b1;
          end
          if ((res_hs || taken_q) && ser_idle) begin
            state_q    <= ACC;
            in_ready_q <= 1'b1;
            taken_q    <= 1'b0;
          end
`else
          if (res_hs) begin
            state_q     <= ACC;
            res_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
`endif
        end
        default: begin
          state_q    <= ACC;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q   <= 1'b0;
      s1_row0_q  <= 1'b0;
      s1_lrow_q  <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_vx_q    <= '0;
      s1_vy_q    <= '0;
      cand_sad_q <= '0;
      s2_done_q  <= 1'b0;
      s2_first_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_vx_q    <= '0;
      s2_vy_q    <= '0;
      min_sad_q  <= '0;
      min_vx_q   <= '0;
      min_vy_q   <= '0;
      res_sad_q  <= '0;
      res_mv_x_q <= '0;
      res_mv_y_q <= '0;
    end else begin
      s1_vld_q <= beat_acc;
      if (beat_acc) begin
        s1_row0_q  <= (pos_row == '0);
        s1_lrow_q  <= at_last_row;
        s1_first_q <= (pos_vx == '0) && (pos_vy == '0);
        s1_last_q  <= at_last_vx && at_last_vy;
        s1_vx_q    <= pos_vx;
        s1_vy_q    <= pos_vy;
      end

      // A restart kills a candidate of the abandoned block that would
      // otherwise complete right behind the in_sob beat.
      s2_done_q <= s1_vld_q && s1_lrow_q && !sob_acc;
      if (s1_vld_q) begin
        cand_sad_q <= (s1_row0_q ? '0 : cand_sad_q) + SAD_W'(row_sad);
        s2_first_q <= s1_first_q;
        s2_last_q  <= s1_last_q;
        s2_vx_q    <= s1_vx_q;
        s2_vy_q    <= s1_vy_q;
      end

      if (sob_acc) begin
        min_sad_q <= '0;
        min_vx_q  <= '0;
        min_vy_q  <= '0;
      end else if (s2_done_q) begin
        min_sad_q <= best_sad;
        min_vx_q  <= best_vx;
        min_vy_q  <= best_vy;
      end

      if (res_load) begin
        res_sad_q  <= best_sad;
        res_mv_x_q <= best_mv_x;
        res_mv_y_q <= best_mv_y;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign res_sad   = res_sad_q;
  assign res_mv_x  = res_mv_x_q;
  assign res_mv_y  = res_mv_y_q;

endmodule

// File: tb/tb_me_search_engine.sv
`timescale 1ns/1ps
module tb_me_search_engine;

  localparam int PIX_W = 8;
  localparam int BLK_W = 8;
  localparam int BLK_H = 16;
  localparam int SR_X  = 16;
  localparam int SR_Y  = 16;
  localparam int SAD_W = 15;
  localparam int MV_XW = 4;
  localparam int MV_YW = 4;
  localparam int RW    = BLK_W * PIX_W;
  localparam int FULL  = SR_X * SR_Y * BLK_H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_sob = 1'b0;
  logic res_ready = 1'b1;
  logic [RW-1:0] cur_row = '0;
  logic [RW-1:0] ref_row = '0;
  logic in_ready, res_valid;
  logic [SAD_W-1:0] res_sad;
  logic signed [MV_XW-1:0] res_mv_x;
  logic signed [MV_YW-1:0] res_mv_y;
`ifdef ME_SERIAL_OUT_EN
  logic ser_en, ser_sad, ser_x, ser_y;
`endif

  me_search_engine #(
    .PIX_W(PIX_W), .BLK_W(BLK_W), .BLK_H(BLK_H), .SR_X(SR_X), .SR_Y(SR_Y)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sob(in_sob), .cur_row(cur_row), .ref_row(ref_row),
    .res_valid(res_valid), .res_ready(res_ready), .res_sad(res_sad),
    .res_mv_x(res_mv_x), .res_mv_y(res_mv_y)
`ifdef ME_SERIAL_OUT_EN
    , .ser_en(ser_en), .ser_sad(ser_sad), .ser_x(ser_x), .ser_y(ser_y)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int sad; int mx; int my; } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int n_pop = 0;
  int n_push = 0;
  bit hold_ready = 1'b0;
  bit rand_ready = 1'b0;

  int cur_p [BLK_H][BLK_W];
  int ref_p [SR_Y][SR_X][BLK_H][BLK_W];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic summary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
  endtask

  // Reference: exhaustive SAD per candidate in raster order, first minimum wins.
  function automatic exp_t model();
    exp_t e;
    int s, d;
    bit first;
    first = 1'b1;
    e.sad = 0; e.mx = 0; e.my = 0;
    for (int vy = 0; vy < SR_Y; vy++)
      for (int vx = 0; vx < SR_X; vx++) begin
        s = 0;
        for (int r = 0; r < BLK_H; r++)
          for (int p = 0; p < BLK_W; p++) begin
            d = cur_p[r][p] - ref_p[vy][vx][r][p];
            s += (d < 0) ? -d : d;
          end
        if (first || s < e.sad) begin
          e.sad = s; e.mx = vx - SR_X / 2; e.my = vy - SR_Y / 2;
          first = 1'b0;
        end
      end
    return e;
  endfunction

  // mode: 0 one exact match at (11,3) / 1 tie at 40 / 2 worst case /
  // 3 fully random / 4 noisy / 5 ref==cur everywhere / 6 exact match at (0,15)
  task automatic fill(input int mode);
    int c, v;
    for (int r = 0; r < BLK_H; r++)
      for (int p = 0; p < BLK_W; p++)
        case (mode)
          0: cur_p[r][p] = $urandom_range(0, 254);
          1: cur_p[r][p] = $urandom_range(0, 250);
          2: cur_p[r][p] = 255;
          6: cur_p[r][p] = $urandom_range(0, 253);
          default: cur_p[r][p] = $urandom_range(0, 255);
        endcase
    for (int vy = 0; vy < SR_Y; vy++)
      for (int vx = 0; vx < SR_X; vx++)
        for (int r = 0; r < BLK_H; r++)
          for (int p = 0; p < BLK_W; p++) begin
            c = cur_p[r][p];
            case (mode)
              0: v = (vx == 11 && vy == 3) ? c : c + 1;
              1: v = ((vx == 2 && vy == 0) || (vx == 5 && vy == 9)) ? c + ((r < 5) ? 1 : 0) : c + 3;
              2: v = 0;
              3: v = $urandom_range(0, 255);
              4: begin
                v = c + $urandom_range(0, 6) - 3;
                if (v < 0) v = 0;
                if (v > 255) v = 255;
              end
              5: v = c;
              default: v = (vx == 0 && vy == 15) ? c : c + 2;
            endcase
            ref_p[vy][vx][r][p] = v;
          end
  endtask

  function automatic logic [RW-1:0] pack_cur(input int r);
    logic [RW-1:0] v;
    v = '0;
    for (int p = 0; p < BLK_W; p++) v[p*PIX_W +: PIX_W] = PIX_W'(cur_p[r][p]);
    return v;
  endfunction

  function automatic logic [RW-1:0] pack_ref(input int vy, input int vx, input int r);
    logic [RW-1:0] v;
    v = '0;
    for (int p = 0; p < BLK_W; p++) v[p*PIX_W +: PIX_W] = PIX_W'(ref_p[vy][vx][r][p]);
    return v;
  endfunction

  // Present a beat from posedge+1, hold until in_ready is seen, return at posedge+1.
  task automatic send_beat(input logic [RW-1:0] c, input logic [RW-1:0] r,
                           input logic sob, input bit no_idle);
    int w;
    w = 0;
    cur_row = c; ref_row = r; in_sob = sob; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && w < 2000) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("beat_accept_timeout", in_ready, 1);
      summary();
      $fatal(1, "stalled waiting for in_ready");
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_sob = 1'b0;
    if (!no_idle && $urandom_range(0, 9) == 0) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_block(input bit sob_first, input int n_beats, input bit chk_lat);
    int k, lat;
    k = 0;
    for (int vy = 0; vy < SR_Y; vy++)
      for (int vx = 0; vx < SR_X; vx++)
        for (int r = 0; r < BLK_H; r++) begin
          if (k == n_beats) return;
          send_beat(pack_cur(r), pack_ref(vy, vx, r), sob_first && (k == 0), k == FULL - 1);
          k++;
        end
    if (chk_lat) begin
      lat = 1;
      while (!res_valid && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      check("latency", lat, 3);
    end
  endtask

  task automatic push_expected(output exp_t e);
    e = model();
    exp_q.push_back(e);
    n_push++;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 5000) begin
      @(posedge clk);
      w++;
    end
    check("queue_drained", exp_q.size(), 0);
  endtask

  // res_ready generator
  initial forever begin
    @(posedge clk); #1;
    if (hold_ready)      res_ready = 1'b0;
    else if (rand_ready) res_ready = ($urandom_range(0, 2) != 0);
    else                 res_ready = 1'b1;
  end

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result_sad", res_sad, -1);
        end else begin
          e = exp_q.pop_front();
          n_pop++;
          check("res_sad", res_sad, e.sad);
          check("res_mv_x", $signed(res_mv_x), e.mx);
          check("res_mv_y", $signed(res_mv_y), e.my);
        end
      end
    end
  end

  initial begin
    #5ms;
    check("watchdog_expired", 1, 0);
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int w;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_sad", res_sad, 0);
    check("rst_res_mv_x", res_mv_x, 0);
    check("rst_res_mv_y", res_mv_y, 0);
    rst = 1'b0;

    fill(0); push_expected(e); send_block(1'b1, FULL, 1'b1);
    fill(1); push_expected(e); send_block(1'b1, FULL, 1'b1);
    fill(2); push_expected(e); send_block(1'b1, FULL, 1'b1);

    // reset part-way through a block, then a block with no in_sob at all
    fill(3); send_block(1'b1, 100, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midblk_rst_in_ready", in_ready, 0);
    check("midblk_rst_res_valid", res_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    rand_ready = 1'b1;
    fill(4); push_expected(e); send_block(1'b0, FULL, 1'b1);
    drain();
    rand_ready = 1'b0;

    // backpressure: result held for 20 cycles
    fill(3);
    hold_ready = 1'b1;
    push_expected(e);
    send_block(1'b1, FULL, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      check("bp_res_valid", res_valid, 1);
      check("bp_res_sad", res_sad, e.sad);
      check("bp_res_mv_x", $signed(res_mv_x), e.mx);
      check("bp_res_mv_y", $signed(res_mv_y), e.my);
      check("bp_in_ready", in_ready, 0);
    end
    hold_ready = 1'b0;
    w = 0;
    @(negedge clk);
    while (!(res_valid && res_ready) && w < 50) begin
      w++;
      @(negedge clk);
    end
    check("bp_handshake_seen", res_valid && res_ready, 1);
    @(posedge clk); #1;
`ifndef ME_SERIAL_OUT_EN
    check("bp_in_ready_after", in_ready, 1);
    check("bp_res_valid_after", res_valid, 0);
`endif

    // restart with in_sob at candidate 37 row 5
    fill(5); send_block(1'b1, 37 * BLK_H + 5, 1'b0);
    fill(6); push_expected(e); send_block(1'b1, FULL, 1'b1);
    drain();

    // reset while a result is pending in OUT
    fill(4);
    hold_ready = 1'b1;
    e = model();
    send_block(1'b1, FULL, 1'b1);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
    check("outrst_res_valid", res_valid, 0);
    check("outrst_res_sad", res_sad, 0);
    check("outrst_res_mv_x", res_mv_x, 0);
    check("outrst_res_mv_y", res_mv_y, 0);
    check("outrst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    hold_ready = 1'b0;
    repeat (30) @(posedge clk);

    check("results_seen", n_pop, n_push);
    check("queue_empty_end", exp_q.size(), 0);
    summary();
    $finish;
  end

endmodule
